// File: rtl/uart_odbiornik_if.sv
// Serial input, frame options and received-byte outputs of the UART receiver.
interface uart_odbiornik_if;
    logic       wejscie_odb;
    logic       czy_parz;
    logic       jaki_parz;
    logic [7:0] slowo_odb;
    logic       gotowe;
    logic       blad_parz;
    logic       blad_ramki;
    logic       odbior;

    modport master (
        input  wejscie_odb, czy_parz, jaki_parz,
        output slowo_odb, gotowe, blad_parz, blad_ramki, odbior
    );

    modport slave (
        output wejscie_odb, czy_parz, jaki_parz,
        input  slowo_odb, gotowe, blad_parz, blad_ramki, odbior
    );
endinterface

// File: rtl/uart_odbiornik.sv
// UART receiver: start, 8 data bits LSB first, optional parity, stop.
// Optional build macro ODB_GLOSOWANIE_EN: 3-sample majority vote per bit.
module uart_odbiornik #(
    parameter int unsigned DZIELNIK = 43
) (
    input  logic             CLK,
    input  logic             RST_N,
    uart_odbiornik_if.master bus
);

    localparam int unsigned POLOWA = DZIELNIK / 2;
    localparam int unsigned CW     = $clog2(DZIELNIK);
`ifdef ODB_GLOSOWANIE_EN
    localparam int unsigned PIERWSZY = POLOWA;
`else
    localparam int unsigned PIERWSZY = POLOWA - 1;
`endif

    typedef enum logic [2:0] {
        BEZCZYNNY,
        START,
        DANE,
        PARZ,
        STOP,
        KONIEC
    } stan_t;

    stan_t          stan;
    logic [CW-1:0]  licznik;
    logic [2:0]     nr_bitu;
    logic [7:0]     rejestr;
    logic           par_en;
    logic           par_typ;
    logic           bit_parz;

    logic           synch1;
    logic           synch2;
    logic           synch_pop;
`ifdef ODB_GLOSOWANIE_EN
    logic           synch_pop2;
`endif

    logic           start_c;
    logic           punkt_c;
    logic           probka_c;

    // Two-flop synchronizer plus history flop(s) for edge detect and voting
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            synch1    <= 1'b1;
            synch2    <= 1'b1;
            synch_pop <= 1'b1;
        end else begin
            synch1    <= bus.wejscie_odb;
            synch2    <= synch1;
            synch_pop <= synch2;
        end
    end

`ifdef ODB_GLOSOWANIE_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) synch_pop2 <= 1'b1;
        else        synch_pop2 <= synch_pop;
    end

    assign probka_c = (synch2 & synch_pop) | (synch2 & synch_pop2) | (synch_pop & synch_pop2);
`else
    assign probka_c = synch2;
`endif

    assign start_c = !synch2 && synch_pop;
    assign punkt_c = (stan == START) ? (licznik == CW'(PIERWSZY))
                                     : (licznik == CW'(DZIELNIK - 1));

    // Receive FSM with registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stan           <= BEZCZYNNY;
            licznik        <= '0;
            nr_bitu        <= '0;
            rejestr        <= '0;
            par_en         <= 1'b0;
            par_typ        <= 1'b0;
            bit_parz       <= 1'b0;
            bus.slowo_odb  <= '0;
            bus.gotowe     <= 1'b0;
            bus.blad_parz  <= 1'b0;
            bus.blad_ramki <= 1'b0;
            bus.odbior     <= 1'b0;
        end else begin
            bus.gotowe <= 1'b0;
            if (stan != BEZCZYNNY) begin
                licznik <= punkt_c ? '0 : licznik + CW'(1);
            end
            case (stan)
                BEZCZYNNY: begin
                    if (start_c) begin
                        stan       <= START;
                        licznik    <= '0;
                        par_en     <= bus.czy_parz;
                        par_typ    <= bus.jaki_parz;
                        bus.odbior <= 1'b1;
                    end
                end
                START: begin
                    if (punkt_c) begin
                        if (!probka_c) begin
                            stan    <= DANE;
                            nr_bitu <= '0;
                        end else begin
                            stan       <= BEZCZYNNY;
                            bus.odbior <= 1'b0;
                        end
                    end
                end
                DANE: begin
                    if (punkt_c) begin
                        rejestr <= {probka_c, rejestr[7:1]};
                        nr_bitu <= nr_bitu + 3'd1;
                        if (nr_bitu == 3'd7) stan <= par_en ? PARZ : STOP;
                    end
                end
                PARZ: begin
                    if (punkt_c) begin
                        bit_parz <= probka_c;
                        stan     <= STOP;
                    end
                end
                STOP: begin
                    if (punkt_c) begin
                        bus.slowo_odb  <= rejestr;
                        bus.blad_parz  <= par_en & (bit_parz != (par_typ ? ~^rejestr : ^rejestr));
                        bus.blad_ramki <= ~probka_c;
                        bus.gotowe     <= 1'b1;
                        stan           <= KONIEC;
                    end
                end
                KONIEC: begin
                    stan       <= BEZCZYNNY;
                    bus.odbior <= 1'b0;
                end
                default: begin
                    stan       <= BEZCZYNNY;
                    bus.odbior <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_odbiornik.sv
// Self-checking bench for uart_odbiornik: frame-level model, per-cycle compare.
module tb_uart_odbiornik;

    localparam int unsigned DZ = 43;
    localparam int unsigned P  = DZ / 2;
`ifdef ODB_GLOSOWANIE_EN
    localparam int unsigned V = 1;
`else
    localparam int unsigned V = 0;
`endif

    logic CLK = 1'b0;
    logic RST_N;

    uart_odbiornik_if bus ();

    uart_odbiornik #(.DZIELNIK(DZ)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // One expected frame: odbior high over [t0, tend], gotowe at tend if g
    typedef struct {
        int unsigned t0;
        int unsigned tend;
        bit          g;
        logic [7:0]  d;
        bit          bp;
        bit          br;
    } ramka_t;

    ramka_t      q[$];
    int unsigned gt[$];
    logic [7:0]  m_slowo;
    logic        m_bp;
    logic        m_br;
    int          checks   = 0;
    int          failures = 0;

    task automatic sprawdz(input string nazwa, input int unsigned akt, input int unsigned ocz);
        checks++;
        if (akt != ocz) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nazwa, cyc, akt, ocz);
        end
    endtask

    // Per-cycle compare of all outputs against the frame model
    always @(negedge CLK) begin
        bit eg;
        bit eo;
        eg = 1'b0;
        eo = 1'b0;
        if (!RST_N) begin
            q.delete();
            m_slowo = 8'h00;
            m_bp    = 1'b0;
            m_br    = 1'b0;
        end else if (q.size() > 0 && cyc >= q[0].t0) begin
            eo = 1'b1;
            if (cyc == q[0].tend && q[0].g) begin
                eg      = 1'b1;
                m_slowo = q[0].d;
                m_bp    = q[0].bp;
                m_br    = q[0].br;
            end
        end
        sprawdz("gotowe",     32'(bus.gotowe),     32'(eg));
        sprawdz("odbior",     32'(bus.odbior),     32'(eo));
        sprawdz("slowo_odb",  32'(bus.slowo_odb),  32'(m_slowo));
        sprawdz("blad_parz",  32'(bus.blad_parz),  32'(m_bp));
        sprawdz("blad_ramki", 32'(bus.blad_ramki), 32'(m_br));
        if (bus.gotowe) gt.push_back(cyc);
        if (q.size() > 0 && cyc >= q[0].tend) void'(q.pop_front());
    end

    task automatic cykle(input int unsigned k);
        repeat (k) @(posedge CLK);
        #1;
    endtask

    // Drive one frame as the transmitter would; options flip after the start bit
    task automatic wyslij(input logic [7:0] d, input logic cp, input logic jp,
                          input logic pb, input logic sb, output int unsigned n);
        logic        bity [0:10];
        int unsigned nb;
        ramka_t      r;
        bity[0] = 1'b0;
        for (int i = 0; i < 8; i++) bity[i+1] = d[i];
        if (cp) begin
            bity[9]  = pb;
            bity[10] = sb;
            nb       = 11;
        end else begin
            bity[9]  = sb;
            bity[10] = 1'b1;
            nb       = 10;
        end
        bus.czy_parz  = cp;
        bus.jaki_parz = jp;
        n      = cyc;
        r.t0   = n + 3;
        r.tend = r.t0 + P + (cp ? 10 : 9) * DZ + V;
        r.g    = 1'b1;
        r.d    = d;
        r.bp   = cp && (pb != (jp ? ~^d : ^d));
        r.br   = ~sb;
        q.push_back(r);
        for (int i = 0; i < int'(nb); i++) begin
            bus.wejscie_odb = bity[i];
            if (i == 1) begin
                bus.czy_parz  = ~cp;
                bus.jaki_parz = ~jp;
            end
            cykle(DZ);
        end
    endtask

    initial begin
        int unsigned n;
        int unsigned ng;
        ramka_t      r;
        logic [7:0]  d;
        logic [1:0]  cc;

        RST_N           = 1'b0;
        bus.wejscie_odb = 1'b1;
        bus.czy_parz    = 1'b0;
        bus.jaki_parz   = 1'b0;
        cykle(4);
        sprawdz("reset_slowo",  32'(bus.slowo_odb), 32'h00);
        sprawdz("reset_odbior", 32'(bus.odbior),    32'h0);
        RST_N = 1'b1;
        cykle(5);

        // 1: no parity, 0xA5
        wyslij(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, n);
        cykle(3);
        sprawdz("t1_liczba_gotowe", 32'(gt.size()), 32'd1);
        sprawdz("t1_latencja", gt[$] - n, 32'd411 + V);
        sprawdz("t1_slowo", 32'(bus.slowo_odb), 32'hA5);

        // 2: parity even/odd correct, then wrong parity
        wyslij(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, n);
        sprawdz("t2_even_bp", 32'(bus.blad_parz), 32'h0);
        wyslij(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, n);
        sprawdz("t2_odd_bp", 32'(bus.blad_parz), 32'h0);
        wyslij(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, n);
        sprawdz("t2_zly_bp", 32'(bus.blad_parz), 32'h1);
        sprawdz("t2_zly_slowo", 32'(bus.slowo_odb), 32'h3C);

        // 3: stop bit 0, line stays low, then recovers
        wyslij(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, n);
        sprawdz("t3_slowo", 32'(bus.slowo_odb), 32'h81);
        sprawdz("t3_br", 32'(bus.blad_ramki), 32'h1);
        ng = gt.size();
        cykle(3 * DZ);
        bus.wejscie_odb = 1'b1;
        cykle(DZ);
        sprawdz("t3_brak_startu", 32'(gt.size()), 32'(ng));

        // 4: 5-cycle low glitch is a false start
        bus.wejscie_odb = 1'b0;
        r.t0   = cyc + 3;
        r.tend = r.t0 + P + V - 1;
        r.g    = 1'b0;
        r.d    = 8'h00;
        r.bp   = 1'b0;
        r.br   = 1'b0;
        q.push_back(r);
        cykle(5);
        bus.wejscie_odb = 1'b1;
        cykle(2 * DZ);
        sprawdz("t4_slowo", 32'(bus.slowo_odb), 32'h81);
        sprawdz("t4_br", 32'(bus.blad_ramki), 32'h1);
        sprawdz("t4_brak_gotowe", 32'(gt.size()), 32'(ng));

        // 5: back-to-back frames
        wyslij(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, n);
        wyslij(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, n);
        sprawdz("t5_liczba", 32'(gt.size()), 32'(ng + 2));
        sprawdz("t5_odstep", gt[$] - gt[$-1], 32'd430);
        sprawdz("t5_slowo", 32'(bus.slowo_odb), 32'hAA);

        // 6: reset during d4 of 0x33, then 0x0F
        bus.czy_parz    = 1'b0;
        bus.wejscie_odb = 1'b0;
        r.t0   = cyc + 3;
        r.tend = r.t0 + P + 9 * DZ + V;
        r.g    = 1'b0;
        q.push_back(r);
        cykle(DZ);
        d = 8'h33;
        for (int i = 0; i < 4; i++) begin
            bus.wejscie_odb = d[i];
            cykle(DZ);
        end
        bus.wejscie_odb = d[4];
        ng = gt.size();
        cykle(DZ / 2);
        RST_N = 1'b0;
        cykle(1);
        sprawdz("t6_reset_slowo", 32'(bus.slowo_odb), 32'h00);
        bus.wejscie_odb = 1'b1;
        cykle(5);
        RST_N = 1'b1;
        cykle(10);
        sprawdz("t6_brak_gotowe", 32'(gt.size()), 32'(ng));
        wyslij(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, n);
        sprawdz("t6_slowo", 32'(bus.slowo_odb), 32'h0F);

        // Byte sweep over all parity option combinations
        for (int i = 0; i < 24; i++) begin
            for (int c = 0; c < 4; c++) begin
                d  = 8'(i * 11);
                cc = 2'(c);
                wyslij(d, cc[1], cc[0], cc[0] ? ~^d : ^d, 1'b1, n);
            end
        end

        for (int k = 0; k < 1000 && q.size() > 0; k++) cykle(1);
        sprawdz("model_oprozniony", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
